// File: rtl/sha1_engine.sv
// Multi-block SHA-1 compression engine: valid/ready block input, chained 160-bit state,
// ROUNDS_PER_CYCLE rounds per clock from a rolling 16-word message schedule.
module sha1_engine #(
    parameter int          ROUNDS_PER_CYCLE = 1,
    parameter logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic [159:0] hash_out,
    output logic         hash_valid,
    output logic         busy
);

    localparam int         RPC      = ROUNDS_PER_CYCLE;
    localparam int         EXT      = 16 + RPC;
    localparam logic [6:0] LAST_RND = 7'(80 - RPC);

    generate
        if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 5 ||
              RPC == 8 || RPC == 10 || RPC == 16 || RPC == 20)) begin : g_bad_rpc
            $error("sha1_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 5, 8, 10, 16 or 20");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t      state;
    logic [31:0] win [16];
    logic [31:0] ext [EXT];
    logic [31:0] h [5];
    logic [31:0] a, b, c, d, e;
    logic [31:0] na, nb, nc, nd, ne, tmp;
    logic [6:0]  rnd;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Boolean function plus round constant for absolute round index r.
    function automatic logic [31:0] round_fk(input logic [6:0] r, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] z);
        if (r < 7'd20)      return ((x & y) | (~x & z)) + 32'h5A827999;
        else if (r < 7'd40) return (x ^ y ^ z) + 32'h6ED9EBA1;
        else if (r < 7'd60) return ((x & y) | (x & z) | (y & z)) + 32'h8F1BBCDC;
        else                return (x ^ y ^ z) + 32'hCA62C1D6;
    endfunction

    // Extend the window by RPC words so up to 20 chained rounds see their W[t] this cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = win[i];
        for (int i = 16; i < EXT; i++)
            ext[i] = rotl(ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16], 1);
        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        ne  = e;
        tmp = '0;
        for (int j = 0; j < RPC; j++) begin
            tmp = rotl(na, 5) + round_fk(rnd + 7'(j), nb, nc, nd) + ne + ext[j];
            ne  = nd;
            nd  = nc;
            nc  = rotl(nb, 30);
            nb  = na;
            na  = tmp;
        end
    end

    assign blk_ready = reset_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hash_out   <= '0;
            hash_valid <= 1'b0;
            busy       <= 1'b0;
            rnd        <= '0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            d          <= '0;
            e          <= '0;
            for (int i = 0; i < 5; i++)  h[i]   <= IV[159-32*i -: 32];
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            hash_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) win[i] <= blk_data[511-32*i -: 32];
                        if (blk_first) begin
                            {a, b, c, d, e} <= IV;
                            for (int i = 0; i < 5; i++) h[i] <= IV[159-32*i -: 32];
                        end else begin
                            {a, b, c, d, e} <= {h[0], h[1], h[2], h[3], h[4]};
                        end
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    {a, b, c, d, e} <= {na, nb, nc, nd, ne};
                    for (int i = 0; i < 16; i++) win[i] <= ext[i+RPC];
                    rnd <= rnd + 7'(RPC);
                    if (rnd == LAST_RND) state <= FINAL;
                end
                FINAL: begin
                    h[0]       <= h[0] + a;
                    h[1]       <= h[1] + b;
                    h[2]       <= h[2] + c;
                    h[3]       <= h[3] + d;
                    h[4]       <= h[4] + e;
                    hash_out   <= {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e};
                    hash_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
